// File: rtl/mac_acc_seq.sv
// Job-level sequencer for one mac_acc_block: takes a command, drives the block's
// cfg/rst/en, streams product beats into it and returns results on a valid/ready stream.
module mac_acc_seq #(
  parameter int MAC_CONF_WIDTH = 3,
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int MAC_ACC_WIDTH  = 4*MAC_MIN_WIDTH,
  parameter int LEN_WIDTH      = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic [1:0]                            cmd_mode,
  input  logic                                  cmd_acc,
  input  logic [LEN_WIDTH-1:0]                  cmd_len,
  input  logic [4*MAC_ACC_WIDTH-1:0]            cmd_init,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [4*MAC_ACC_WIDTH-1:0]            in_data,
  output logic [4*MAC_ACC_WIDTH+MAC_CONF_WIDTH-1:0] blk_cfg,
  output logic                                  blk_rst,
  output logic                                  blk_en,
  output logic [4*MAC_ACC_WIDTH-1:0]            blk_in,
  input  logic [4*MAC_ACC_WIDTH-1:0]            blk_out,
  output logic                                  res_valid,
  input  logic                                  res_ready,
  output logic [4*MAC_ACC_WIDTH-1:0]            res_data,
  output logic                                  busy
);

  localparam int DW = 4*MAC_ACC_WIDTH;
  localparam int CW = DW + MAC_CONF_WIDTH;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, FLUSH, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cfg_q, cfg_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic                 res_valid_q, res_valid_d;
  logic [DW-1:0]        res_data_q, res_data_d;

  logic acc_mode;
  logic cnt_done;
  logic beat_fire;

  assign acc_mode  = cfg_q[2];
  assign cnt_done  = (cnt_q >= len_q);
  assign beat_fire = in_valid & in_ready;

  // Multiply-only mode admits one beat at a time so each product can be captured alone.
  always_comb begin
    in_ready = 1'b0;
    if (state_q == RUN) begin
      if (acc_mode) in_ready = ~cnt_done;
      else          in_ready = ~pend_q & ~res_valid_q & ~cnt_done;
    end
  end

  assign blk_en    = (state_q == RUN) & acc_mode & beat_fire;
  assign blk_rst   = ~rst_n | (state_q == LOAD);
  assign blk_cfg   = cfg_q;
  assign blk_in    = in_data;
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    if (beat_fire && !cnt_done) cnt_d = cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cfg_d   = {cmd_init, cmd_acc, cmd_mode};
          len_d   = cmd_len;
          cnt_d   = '0;
          state_d = cmd_acc ? LOAD : RUN;
        end
      end
      LOAD: state_d = (len_q != '0) ? RUN : FLUSH;
      RUN: begin
        if (acc_mode) begin
          if (beat_fire && (cnt_d == len_q)) state_d = FLUSH;
        end else begin
          // The block's pass-through register holds the beat one edge after accept.
          if (beat_fire) pend_d = 1'b1;
          if (pend_q) begin
            res_data_d  = blk_out;
            res_valid_d = 1'b1;
            pend_d      = 1'b0;
          end
          if (res_valid_q && res_ready) res_valid_d = 1'b0;
          if (cnt_done && !pend_q && !res_valid_q) state_d = IDLE;
        end
      end
      FLUSH: begin
        res_data_d  = blk_out;
        res_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cfg_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

endmodule

// File: tb/tb_mac_acc_seq.sv
// Bench for mac_acc_seq: a behavioural mac_acc_block stands in for the real block, jobs are
// issued from a driver, and a monitor pops expected results from a scoreboard queue.
module tb_mac_acc_seq;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_DUAL   = 2'd1;
  localparam logic [1:0] MODE_QUAD   = 2'd2;

  logic         clk;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_mode;
  logic         cmd_acc;
  logic [15:0]  cmd_len;
  logic [127:0] cmd_init;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [130:0] blk_cfg;
  logic         blk_rst;
  logic         blk_en;
  logic [127:0] blk_in;
  logic [127:0] blk_out;
  logic         res_valid;
  logic         res_ready;
  logic [127:0] res_data;
  logic         busy;

  typedef struct {
    logic [127:0] data;
    int           edge_n;
  } exp_t;

  exp_t         exp_q[$];
  logic [127:0] beat_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           rr_mode = 0;
  logic [127:0] last_res;
  logic [127:0] held;
  bit           seen = 0;
  exp_t         e;
  logic [127:0] blk_acc;

  mac_acc_seq dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_acc(cmd_acc),
    .cmd_len(cmd_len), .cmd_init(cmd_init),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .blk_cfg(blk_cfg), .blk_rst(blk_rst), .blk_en(blk_en), .blk_in(blk_in), .blk_out(blk_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Lane-mode addition: four 32-bit lanes, two 64-bit lanes, or one 128-bit lane.
  function automatic logic [127:0] lane_add(input logic [1:0] mode, input logic [127:0] a,
                                            input logic [127:0] b);
    logic [127:0] r;
    r = '0;
    case (mode)
      MODE_SINGLE: for (int k = 0; k < 4; k++) r[k*32 +: 32] = a[k*32 +: 32] + b[k*32 +: 32];
      MODE_DUAL:   for (int k = 0; k < 2; k++) r[k*64 +: 64] = a[k*64 +: 64] + b[k*64 +: 64];
      default:     r = a + b;
    endcase
    return r;
  endfunction

  // Stand-in for mac_acc_block: init on reset, pass-through when not accumulating.
  always @(posedge clk) begin
    if (blk_rst)          blk_acc <= blk_cfg[130:3];
    else if (!blk_cfg[2]) blk_acc <= blk_in;
    else if (blk_en)      blk_acc <= lane_add(blk_cfg[1:0], blk_acc, blk_in);
  end
  assign blk_out = blk_acc;

  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       res_ready = ($urandom_range(0, 2) != 0);
        1:       res_ready = 1'b0;
        default: res_ready = 1'b1;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [130:0] act, input logic [130:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name, input string why);
    n_cmp++;
    n_err++;
    $display("[TB] FAIL %s: %s", name, why);
  endtask

  // Monitor: each new result is matched against the oldest expectation, then must hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 0;
    end else if (res_valid) begin
      if (!seen) begin
        if (exp_q.size() == 0) begin
          failNow("unexpected_result", $sformatf("result %0h with nothing expected", res_data));
        end else begin
          e = exp_q.pop_front();
          checkOutput("res_data", res_data, e.data);
          checkOutput("res_latency", cyc, e.edge_n);
        end
        held     = res_data;
        last_res = res_data;
        seen     = 1;
      end else begin
        checkOutput("res_hold", res_data, held);
      end
      if (res_ready) seen = 0;
    end
  end

  // Issues one job from beat_q; stop_after >= 0 abandons it after that many beats.
  task automatic applyStimulus(input logic [1:0] mode, input logic acc, input int len,
                               input logic [127:0] init, input int stop_after);
    logic [127:0] sum;
    int cmd_edge, last_edge, n;
    bit got;
    sum = init;
    last_edge = 0;
    cmd_edge = 0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_acc   = acc;
    cmd_len   = len[15:0];
    cmd_init  = init;
    got = 0;
    n = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      if (cmd_ready) begin
        got = 1;
        cmd_edge = cyc + 1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    cmd_valid = 1'b0;
    if (!got) begin
      failNow("cmd_accept", "command never accepted");
      return;
    end
    checkOutput("blk_cfg", blk_cfg, {init, acc, mode});
    if (acc && len == 0) exp_q.push_back('{init, cmd_edge + 2});
    for (int i = 0; i < len; i++) begin
      if (i == stop_after) begin
        in_valid = 1'b0;
        return;
      end
      got = 0;
      n = 0;
      while (!got && n < 500) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = beat_q[i];
        @(negedge clk);
        if (in_valid && in_ready) begin
          got = 1;
          last_edge = cyc + 1;
        end
        @(posedge clk);
        #1;
        n++;
      end
      in_valid = 1'b0;
      if (!got) begin
        failNow("beat_accept", $sformatf("beat %0d never accepted", i));
        return;
      end
      if (acc) begin
        sum = lane_add(mode, sum, beat_q[i]);
      end else begin
        exp_q.push_back('{beat_q[i], last_edge + 1});
        @(negedge clk);
        checkOutput("in_ready_pend", in_ready, 1'b0);
        @(posedge clk);
        #1;
      end
    end
    if (acc && len > 0) exp_q.push_back('{sum, last_edge + 1});
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || exp_q.size() != 0) && n < 1000);
    if (busy || exp_q.size() != 0) failNow(name, "timeout waiting for job to finish");
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [127:0] init_v;
    int n;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_mode = 2'd0;
    cmd_acc = 1'b0;
    cmd_len = '0;
    cmd_init = '0;
    in_valid = 1'b0;
    in_data = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_blk_rst", blk_rst, 1'b1);
    checkOutput("rst_res_valid", res_valid, 1'b0);
    checkOutput("rst_res_data", res_data, 128'd0);
    checkOutput("rst_blk_cfg", blk_cfg, 131'd0);
    checkOutput("rst_in_ready", in_ready, 1'b0);
    checkOutput("rst_blk_en", blk_en, 1'b0);
    checkOutput("rst_cmd_ready", cmd_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_blk_rst", blk_rst, 1'b0);

    $display("[TB] single accumulate");
    beat_q = '{128'd1, 128'd2, 128'd3};
    applyStimulus(MODE_SINGLE, 1'b1, 3, 128'd5, -1);
    waitIdle("single_acc_done");
    checkOutput("single_acc_value", last_res, 128'd11);

    $display("[TB] dual carry vs single");
    beat_q = '{128'd1};
    applyStimulus(MODE_DUAL, 1'b1, 1, {96'd0, 32'hFFFF_FFFF}, -1);
    waitIdle("dual_done");
    checkOutput("dual_carry", last_res, 128'h1_0000_0000);
    applyStimulus(MODE_SINGLE, 1'b1, 1, {96'd0, 32'hFFFF_FFFF}, -1);
    waitIdle("single_done");
    checkOutput("single_no_carry", last_res, 128'd0);

    $display("[TB] multiply-only");
    beat_q = '{{32'd0, 32'hA, 64'd0}, {32'd0, 32'hB, 64'd0}};
    applyStimulus(MODE_SINGLE, 1'b0, 2, 128'd0, -1);
    waitIdle("mul_done");
    checkOutput("mul_last", last_res, {32'd0, 32'hB, 64'd0});

    $display("[TB] backpressure in DONE");
    rr_mode = 1;
    init_v = {$urandom, $urandom, $urandom, $urandom};
    beat_q = '{128'd3, 128'd4};
    applyStimulus(MODE_QUAD, 1'b1, 2, init_v, -1);
    n = 0;
    while (!res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) failNow("bp_result", "no result before backpressure");
    for (int k = 0; k < 5; k++) begin
      cmd_valid = 1'b1;
      cmd_acc   = 1'b0;
      cmd_len   = 16'd7;
      cmd_init  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("bp_res_valid", res_valid, 1'b1);
      checkOutput("bp_res_data", res_data, init_v + 128'd7);
      checkOutput("bp_cmd_ready", cmd_ready, 1'b0);
      checkOutput("bp_blk_cfg", blk_cfg, {init_v, 1'b1, MODE_QUAD});
    end
    cmd_valid = 1'b0;
    rr_mode = 2;
    waitIdle("bp_release");
    checkOutput("bp_idle_cmd_ready", cmd_ready, 1'b1);
    rr_mode = 0;

    $display("[TB] zero-length jobs");
    beat_q = {};
    applyStimulus(MODE_SINGLE, 1'b1, 0, {32'd4, 32'd3, 32'd2, 32'd1}, -1);
    waitIdle("len0_acc_done");
    checkOutput("len0_acc_value", last_res, {32'd4, 32'd3, 32'd2, 32'd1});
    applyStimulus(MODE_SINGLE, 1'b0, 0, 128'd9, -1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("len0_mul_no_result", res_valid, 1'b0);
    end
    checkOutput("len0_mul_idle", busy, 1'b0);

    $display("[TB] reset mid-run");
    beat_q = '{128'd1, 128'd2, 128'd3, 128'd4};
    applyStimulus(MODE_SINGLE, 1'b1, 4, 128'd100, 2);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_blk_rst", blk_rst, 1'b1);
    checkOutput("abort_res_valid", res_valid, 1'b0);
    checkOutput("abort_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    beat_q = '{128'd7, 128'd8, 128'd9};
    applyStimulus(MODE_SINGLE, 1'b1, 3, 128'd0, -1);
    waitIdle("post_abort_done");
    checkOutput("post_abort_sum", last_res, 128'd24);

    $display("[TB] random jobs");
    for (int j = 0; j < 25; j++) begin
      int len;
      logic acc;
      logic [1:0] mode;
      len  = $urandom_range(0, 5);
      acc  = $urandom_range(0, 1);
      mode = 2'($urandom_range(0, 2));
      beat_q = {};
      for (int b = 0; b < len; b++) beat_q.push_back({$urandom, $urandom, $urandom, $urandom});
      applyStimulus(mode, acc, len, {$urandom, $urandom, $urandom, $urandom}, -1);
      waitIdle("random_done");
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mac_acc_seq.md
Name: mac_acc_seq

Overview:
- Job-level sequencer for one mac_acc_block instance.
- Accepts a command over a valid/ready handshake: mode, accumulate flag, beat count, four initial accumulator values.
- Drives the block's cfg, rst and en from a registered copy of the command, streams product beats into it, and returns results on a valid/ready output stream.
- Sits between the multiplier array output and the fabric-facing result interface.

Parameters:
- MAC_CONF_WIDTH, 3, config bits in blk_cfg; bits [1:0] are the mode (MAC_SINGLE/MAC_DUAL/MAC_QUAD from mac_const.vh), bit [2] is the accumulate enable.
- MAC_MIN_WIDTH, 8, minimum lane granule.
- MAC_ACC_WIDTH, 4*MAC_MIN_WIDTH, width of one accumulator lane.
- LEN_WIDTH, 16, width of the beat counter and cmd_len.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_mode  in  2  lane mode, copied to blk_cfg[1:0]
- cmd_acc  in  1  1 = accumulate, 0 = multiply-only; copied to blk_cfg[2]
- cmd_len  in  LEN_WIDTH  number of input beats
- cmd_init  in  4*MAC_ACC_WIDTH  lane3..lane0 initial values
- in_valid  in  1  product beat offered
- in_ready  out  1  beat accepted when in_valid & in_ready
- in_data  in  4*MAC_ACC_WIDTH  lane3..lane0 products
- blk_cfg  out  4*MAC_ACC_WIDTH+MAC_CONF_WIDTH  {cmd_init, cmd_acc, cmd_mode}, registered
- blk_rst  out  1  active-high reset to block; loads init values into the accumulators
- blk_en  out  1  accumulate enable
- blk_in  out  4*MAC_ACC_WIDTH  equals in_data
- blk_out  in  4*MAC_ACC_WIDTH  {out3..out0} from block
- res_valid  out  1  result held
- res_ready  in  1  result consumed when res_valid & res_ready
- res_data  out  4*MAC_ACC_WIDTH  registered result
- busy  out  1  state != IDLE

Behaviour:
- Reset values (rst_n low): state IDLE, blk_cfg 0, beat counter 0, pend 0, res_valid 0, res_data 0, blk_en 0, in_ready 0.
  - blk_rst = ~rst_n OR load_pulse, so the block clears while rst_n is low.
  - A reset asserted in any state aborts the job; any partial result is discarded.
- States: IDLE, LOAD, RUN, FLUSH, DONE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, register blk_cfg and cmd_len, clear the counter.
  - cmd_acc=1 -> LOAD; cmd_acc=0 -> RUN.
- LOAD (1 cycle):
  - load_pulse = 1, so blk_rst = 1 and the accumulators take the init values from blk_cfg.
  - Next state: RUN if len > 0, else FLUSH.
- RUN, accumulate mode:
  - in_ready = 1; blk_en = in_valid & in_ready; each accepted beat increments the counter.
  - The cycle accepting beat len -> FLUSH.
- RUN, multiply-only mode:
  - blk_en = 0; in_ready = ~pend & ~res_valid & (count < len).
  - Accept at edge E0 sets pend. The block's pass-through register holds the beat after E0.
  - At E1: res_data <= blk_out, res_valid <= 1, pend <= 0. Result latency = 2 edges; maximum rate 1 beat per 3 cycles without backpressure.
  - res_valid clears on res_ready.
  - When count == len, pend = 0 and res_valid = 0 -> IDLE.
  - len = 0 -> IDLE on the next cycle with no result.
- FLUSH (1 cycle): blk_en = 0; res_data <= blk_out (final accumulator value); res_valid <= 1 -> DONE.
- DONE: hold res_valid/res_data until res_ready, then -> IDLE.
  - cmd_ready stays 0 until the IDLE cycle, so a new command is accepted at the earliest one cycle after the handshake.
- Arithmetic:
  - Lane carries and overflow belong to mac_acc_block; the controller performs no arithmetic besides the counter.
  - The counter saturates at len.
- blk_cfg is stable from command accept until return to IDLE; a mid-job cmd_valid is ignored (cmd_ready = 0).
- In accumulate mode, in_valid low stalls the job indefinitely with blk_en = 0; accumulator values hold.

Test Plan:
- Single accumulate: init lane0=5, len=3, lane0 beats 1,2,3 -> one result, lane0=11, res_valid exactly 2 cycles after the 3rd accept (FLUSH, DONE).
- Dual carry: mode DUAL, init lane0=0xFFFFFFFF, lane1=0, len=1, beat lane0=1 -> res lane0=0, lane1=1; same stimulus in SINGLE mode -> lane1=0.
- Multiply-only: len=2, beats 0xA, 0xB in lane2 -> two results lane2=0xA then 0xB, each 2 edges after its accept; in_ready low in between.
- Backpressure: accumulate job with res_ready held low 5 cycles in DONE -> res_valid and res_data stable, cmd_ready=0, cmd_valid ignored; after res_ready -> IDLE, next command accepted.
- len=0: accumulate with init {4,3,2,1} -> result {4,3,2,1} with no input beats; multiply-only -> back to IDLE, no res_valid.
- Reset mid-RUN after 2 of 4 beats -> immediately IDLE, blk_rst high during reset, res_valid 0; a following job with init 0 produces only its own sum.
